// File: rtl/hash_lane_sched.sv
// ---------------------------------------------------------------------------
// hash_lane_sched
//   Packs incoming sample positions into groups of SAMPLES hash lanes. A group
//   is issued downstream under credit-based flow control. The block can also
//   change the active subsample width, but only once the downstream pipeline
//   has fully drained.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   samp_in_valid/ready      sample handshake
//   samp_in_S                sample position, [0]=x, [1]=y
//   samp_in_last             sample closes its triangle
//   credit_ret               downstream freed one group slot
//   cfg_load, cfg_sub_in     request a new one-hot subsample width
//   sample_R14S              issued lane positions
//   validSamp_R14H           per-lane valid of the issued group
//   issue_R14H               one-cycle strobe: a group is presented
//   triEnd_R14H              issued group was closed by samp_in_last
//   subSample_RnnnnU         active subsample width (one-hot)
//   err_H                    sticky error (credit overflow, bad config)
// ---------------------------------------------------------------------------
module hash_lane_sched #(
    parameter int SIGFIG  = 24,
    parameter int SAMPLES = 2,
    parameter int CREDITS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     samp_in_valid,
    output logic                                     samp_in_ready,
    input  logic signed [1:0][SIGFIG-1:0]            samp_in_S,
    input  logic                                     samp_in_last,
    input  logic                                     credit_ret,
    input  logic                                     cfg_load,
    input  logic        [3:0]                        cfg_sub_in,
    output logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0] sample_R14S,
    output logic        [SAMPLES-1:0]                validSamp_R14H,
    output logic                                     issue_R14H,
    output logic                                     triEnd_R14H,
    output logic        [3:0]                        subSample_RnnnnU,
    output logic                                     err_H
);

    localparam int LW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    typedef enum logic [1:0] {FILL, HOLD, DRAIN} state_t;

    state_t                              state_q, state_d;
    logic [LW-1:0]                       lane_q, lane_d;
    logic [SAMPLES-1:0][1:0][SIGFIG-1:0] buf_pos_q, buf_pos_d;
    logic [SAMPLES-1:0]                  buf_vld_q, buf_vld_d;
    logic                                buf_last_q, buf_last_d;
    logic [3:0]                          credits_q, credits_d;
    logic [3:0]                          sub_q, sub_d;
    logic                                err_q, err_d;
    logic                                cfg_pend_q, cfg_pend_d;
    logic [3:0]                          cfg_val_q, cfg_val_d;
    logic [SAMPLES-1:0][1:0][SIGFIG-1:0] out_pos_q, out_pos_d;
    logic [SAMPLES-1:0]                  out_vld_q, out_vld_d;
    logic                                issue_q, issue_d;
    logic                                tri_q, tri_d;

    // Group contents as they will look once this cycle's sample (if any) lands.
    logic [SAMPLES-1:0][1:0][SIGFIG-1:0] fill_pos, masked_pos;
    logic [SAMPLES-1:0]                  fill_vld;
    logic                                fill_last;
    logic                                accept, complete, credit_avail;
    logic                                cfg_take, pend_now, do_issue;
    logic [3:0]                          val_now;

    assign samp_in_ready = rst && (state_q == FILL);
    assign accept        = samp_in_valid && samp_in_ready;
    assign complete      = accept && ((lane_q == LW'(SAMPLES - 1)) || samp_in_last);
    // A credit returned this cycle can be spent this cycle, so a held group
    // leaves on the cycle right after the credit_ret pulse.
    assign credit_avail  = (credits_q != 4'd0) || credit_ret;
    assign cfg_take      = cfg_load && (state_q != DRAIN);
    assign pend_now      = cfg_pend_q || cfg_take;
    assign val_now       = cfg_take ? cfg_sub_in : cfg_val_q;
    assign fill_last     = buf_last_q || (accept && samp_in_last);

    genvar gi;
    generate
        for (gi = 0; gi < SAMPLES; gi++) begin : g_lane
            logic hit;
            assign hit            = accept && (lane_q == LW'(gi));
            assign fill_pos[gi]   = hit ? samp_in_S : buf_pos_q[gi];
            assign fill_vld[gi]   = buf_vld_q[gi] || hit;
            // Unfilled lanes are presented as zero.
            assign masked_pos[gi] = fill_vld[gi] ? fill_pos[gi] : '0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        buf_pos_d  = fill_pos;
        buf_vld_d  = fill_vld;
        buf_last_d = fill_last;
        credits_d  = credits_q;
        sub_d      = sub_q;
        err_d      = err_q;
        cfg_pend_d = pend_now;
        cfg_val_d  = val_now;
        out_pos_d  = '0;
        out_vld_d  = '0;
        issue_d    = 1'b0;
        tri_d      = 1'b0;
        do_issue   = 1'b0;

        if (accept) begin
            lane_d = complete ? '0 : lane_q + LW'(1);
        end

        case (state_q)
            FILL: begin
                if (complete) begin
                    if (credit_avail) begin
                        do_issue = 1'b1;
                        state_d  = pend_now ? DRAIN : FILL;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (pend_now && (lane_q == '0) && !accept) begin
                    // No partial group outstanding: start draining now.
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (credit_avail) begin
                    do_issue = 1'b1;
                    state_d  = pend_now ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if ((credits_q == CRED_MAX) && (lane_q == '0)) begin
                    state_d    = FILL;
                    cfg_pend_d = 1'b0;
                    if ((cfg_val_q != 4'd0) && ((cfg_val_q & (cfg_val_q - 4'd1)) == 4'd0)) begin
                        sub_d = cfg_val_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (do_issue) begin
            issue_d    = 1'b1;
            tri_d      = fill_last;
            out_pos_d  = masked_pos;
            out_vld_d  = fill_vld;
            buf_pos_d  = '0;
            buf_vld_d  = '0;
            buf_last_d = 1'b0;
        end

        if (do_issue && !credit_ret) begin
            credits_d = credits_q - 4'd1;
        end else if (credit_ret && !do_issue) begin
            if (credits_q == CRED_MAX) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= FILL;
            lane_q     <= '0;
            buf_pos_q  <= '0;
            buf_vld_q  <= '0;
            buf_last_q <= 1'b0;
            credits_q  <= CRED_MAX;
            sub_q      <= 4'b1000;
            err_q      <= 1'b0;
            cfg_pend_q <= 1'b0;
            cfg_val_q  <= 4'd0;
            out_pos_q  <= '0;
            out_vld_q  <= '0;
            issue_q    <= 1'b0;
            tri_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            buf_pos_q  <= buf_pos_d;
            buf_vld_q  <= buf_vld_d;
            buf_last_q <= buf_last_d;
            credits_q  <= credits_d;
            sub_q      <= sub_d;
            err_q      <= err_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_val_q  <= cfg_val_d;
            out_pos_q  <= out_pos_d;
            out_vld_q  <= out_vld_d;
            issue_q    <= issue_d;
            tri_q      <= tri_d;
        end
    end

    assign sample_R14S      = out_pos_q;
    assign validSamp_R14H   = out_vld_q;
    assign issue_R14H       = issue_q;
    assign triEnd_R14H      = tri_q;
    assign subSample_RnnnnU = sub_q;
    assign err_H            = err_q;

endmodule

// File: tb/tb_hash_lane_sched.sv
// ---------------------------------------------------------------------------
// tb_hash_lane_sched
//   Directed checks of hash_lane_sched with SAMPLES=2, CREDITS=4. Inputs are
//   driven 1 time unit after each rising edge; outputs are sampled at the same
//   point, so they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_hash_lane_sched;
    localparam int SIGFIG  = 24;
    localparam int SAMPLES = 2;
    localparam int CREDITS = 4;

    logic                                     clk = 1'b0;
    logic                                     rst = 1'b0;
    logic                                     samp_in_valid = 1'b0;
    logic                                     samp_in_ready;
    logic signed [1:0][SIGFIG-1:0]            samp_in_S = '0;
    logic                                     samp_in_last = 1'b0;
    logic                                     credit_ret = 1'b0;
    logic                                     cfg_load = 1'b0;
    logic        [3:0]                        cfg_sub_in = 4'd0;
    logic signed [SAMPLES-1:0][1:0][SIGFIG-1:0] sample_R14S;
    logic        [SAMPLES-1:0]                validSamp_R14H;
    logic                                     issue_R14H;
    logic                                     triEnd_R14H;
    logic        [3:0]                        subSample_RnnnnU;
    logic                                     err_H;

    int n_cmp = 0;
    int n_err = 0;

    // {y, x}
    logic [1:0][SIGFIG-1:0] pa = {24'h000011, 24'h000022};
    logic [1:0][SIGFIG-1:0] pb = {24'hFFFF33, 24'h000044};
    logic [1:0][SIGFIG-1:0] pc = {24'h123456, 24'hABCDEF};
    logic [1:0][SIGFIG-1:0] pd = {24'h00F00D, 24'h0BEEF0};
    logic [1:0][SIGFIG-1:0] zero_pos = '0;

    hash_lane_sched #(.SIGFIG(SIGFIG), .SAMPLES(SAMPLES), .CREDITS(CREDITS)) dut (
        .clk              (clk),
        .rst              (rst),
        .samp_in_valid    (samp_in_valid),
        .samp_in_ready    (samp_in_ready),
        .samp_in_S        (samp_in_S),
        .samp_in_last     (samp_in_last),
        .credit_ret       (credit_ret),
        .cfg_load         (cfg_load),
        .cfg_sub_in       (cfg_sub_in),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .issue_R14H       (issue_R14H),
        .triEnd_R14H      (triEnd_R14H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .err_H            (err_H)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_credit();
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b want 0", samp_in_ready); end
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL reset_issue got %0b want 0", issue_R14H); end
        n_cmp++; if (validSamp_R14H !== 2'b00) begin n_err++; $display("FAIL reset_vld got %b want 00", validSamp_R14H); end
        n_cmp++; if (subSample_RnnnnU !== 4'b1000) begin n_err++; $display("FAIL reset_sub got %b want 1000", subSample_RnnnnU); end
        n_cmp++; if (err_H !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", err_H); end
        rst = 1'b1;
        tick();
        n_cmp++; if (samp_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_rel_ready got %0b want 1", samp_in_ready); end
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL reset_rel_issue got %0b want 0", issue_R14H); end
        $display("test_reset done");
    endtask

    task automatic test_pair();
        samp_in_valid = 1'b1; samp_in_last = 1'b0; samp_in_S = pa;
        tick();
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL pair_early_issue got %0b want 0", issue_R14H); end
        samp_in_S = pb;
        tick();
        samp_in_valid = 1'b0;
        n_cmp++; if (issue_R14H !== 1'b1) begin n_err++; $display("FAIL pair_issue got %0b want 1", issue_R14H); end
        n_cmp++; if (validSamp_R14H !== 2'b11) begin n_err++; $display("FAIL pair_vld got %b want 11", validSamp_R14H); end
        n_cmp++; if (sample_R14S[0] !== pa) begin n_err++; $display("FAIL pair_lane0 got %h want %h", sample_R14S[0], pa); end
        n_cmp++; if (sample_R14S[1] !== pb) begin n_err++; $display("FAIL pair_lane1 got %h want %h", sample_R14S[1], pb); end
        n_cmp++; if (triEnd_R14H !== 1'b0) begin n_err++; $display("FAIL pair_tri got %0b want 0", triEnd_R14H); end
        tick();
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL pair_one_shot got %0b want 0", issue_R14H); end
        n_cmp++; if (sample_R14S[0] !== zero_pos) begin n_err++; $display("FAIL pair_idle_pos got %h want 0", sample_R14S[0]); end
        n_cmp++; if (validSamp_R14H !== 2'b00) begin n_err++; $display("FAIL pair_idle_vld got %b want 00", validSamp_R14H); end
        pulse_credit();
        $display("test_pair done");
    endtask

    task automatic test_last();
        samp_in_valid = 1'b1; samp_in_last = 1'b1; samp_in_S = pc;
        tick();
        samp_in_valid = 1'b0; samp_in_last = 1'b0;
        n_cmp++; if (issue_R14H !== 1'b1) begin n_err++; $display("FAIL last_issue got %0b want 1", issue_R14H); end
        n_cmp++; if (validSamp_R14H !== 2'b01) begin n_err++; $display("FAIL last_vld got %b want 01", validSamp_R14H); end
        n_cmp++; if (sample_R14S[0] !== pc) begin n_err++; $display("FAIL last_lane0 got %h want %h", sample_R14S[0], pc); end
        n_cmp++; if (sample_R14S[1] !== zero_pos) begin n_err++; $display("FAIL last_lane1 got %h want 0", sample_R14S[1]); end
        n_cmp++; if (triEnd_R14H !== 1'b1) begin n_err++; $display("FAIL last_tri got %0b want 1", triEnd_R14H); end
        pulse_credit();
        $display("test_last done");
    endtask

    // Spend all credits with single-sample groups, then one more to force HOLD.
    task automatic test_hold();
        samp_in_valid = 1'b1; samp_in_last = 1'b1;
        for (int i = 0; i < CREDITS; i++) begin
            samp_in_S = {24'(i + 1), 24'(i + 100)};
            tick();
            n_cmp++; if (issue_R14H !== 1'b1) begin n_err++; $display("FAIL hold_burst_issue[%0d] got %0b want 1", i, issue_R14H); end
            n_cmp++; if (sample_R14S[0] !== {24'(i + 1), 24'(i + 100)}) begin n_err++; $display("FAIL hold_burst_pos[%0d] got %h", i, sample_R14S[0]); end
        end
        samp_in_S = pd;
        tick();
        samp_in_valid = 1'b0; samp_in_last = 1'b0;
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL hold_no_issue got %0b want 0", issue_R14H); end
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready got %0b want 0", samp_in_ready); end
        tick();
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready2 got %0b want 0", samp_in_ready); end
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL hold_no_issue2 got %0b want 0", issue_R14H); end
        pulse_credit();
        n_cmp++; if (issue_R14H !== 1'b1) begin n_err++; $display("FAIL hold_release_issue got %0b want 1", issue_R14H); end
        n_cmp++; if (sample_R14S[0] !== pd) begin n_err++; $display("FAIL hold_release_pos got %h want %h", sample_R14S[0], pd); end
        n_cmp++; if (triEnd_R14H !== 1'b1) begin n_err++; $display("FAIL hold_release_tri got %0b want 1", triEnd_R14H); end
        n_cmp++; if (samp_in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready got %0b want 1", samp_in_ready); end
        // Issue and credit_ret coincided, so the counter is still 0:
        // exactly CREDITS returns refill it without an overflow.
        for (int i = 0; i < CREDITS; i++) pulse_credit();
        n_cmp++; if (err_H !== 1'b0) begin n_err++; $display("FAIL hold_refill_err got %0b want 0", err_H); end
        $display("test_hold done");
    endtask

    task automatic test_credit_overflow();
        pulse_credit();
        n_cmp++; if (err_H !== 1'b1) begin n_err++; $display("FAIL ovf_err got %0b want 1", err_H); end
        // Counter must have stayed at CREDITS: exactly CREDITS groups issue.
        samp_in_valid = 1'b1; samp_in_last = 1'b1; samp_in_S = pa;
        for (int i = 0; i < CREDITS; i++) begin
            tick();
            n_cmp++; if (issue_R14H !== 1'b1) begin n_err++; $display("FAIL ovf_issue[%0d] got %0b want 1", i, issue_R14H); end
        end
        tick();
        samp_in_valid = 1'b0; samp_in_last = 1'b0;
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL ovf_extra_issue got %0b want 0", issue_R14H); end
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_hold_ready got %0b want 0", samp_in_ready); end
        n_cmp++; if (err_H !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %0b want 1", err_H); end
        $display("test_credit_overflow done");
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; tick(); rst = 1'b1; tick();
        samp_in_valid = 1'b1; samp_in_last = 1'b0; samp_in_S = pa;
        tick();
        samp_in_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (issue_R14H !== 1'b0) begin n_err++; $display("FAIL rmid_issue got %0b want 0", issue_R14H); end
        n_cmp++; if (err_H !== 1'b0) begin n_err++; $display("FAIL rmid_err got %0b want 0", err_H); end
        samp_in_valid = 1'b1; samp_in_last = 1'b1; samp_in_S = pb;
        tick();
        samp_in_valid = 1'b0; samp_in_last = 1'b0;
        n_cmp++; if (validSamp_R14H !== 2'b01) begin n_err++; $display("FAIL rmid_vld got %b want 01", validSamp_R14H); end
        n_cmp++; if (sample_R14S[0] !== pb) begin n_err++; $display("FAIL rmid_lane0 got %h want %h", sample_R14S[0], pb); end
        pulse_credit();
        $display("test_reset_mid done");
    endtask

    task automatic test_cfg();
        samp_in_valid = 1'b1; samp_in_last = 1'b0; samp_in_S = pa;
        tick();
        samp_in_S = pb;
        tick();
        samp_in_S = pc; samp_in_last = 1'b1;
        tick();
        samp_in_valid = 1'b0; samp_in_last = 1'b0;
        // Two credits outstanding now.
        cfg_load = 1'b1; cfg_sub_in = 4'b0010;
        tick();
        cfg_load = 1'b0;
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL cfg_drain_ready got %0b want 0", samp_in_ready); end
        n_cmp++; if (subSample_RnnnnU !== 4'b1000) begin n_err++; $display("FAIL cfg_early_sub got %b want 1000", subSample_RnnnnU); end
        pulse_credit();
        // A request arriving during DRAIN must be ignored.
        cfg_load = 1'b1; cfg_sub_in = 4'b0001;
        pulse_credit();
        cfg_load = 1'b0;
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL cfg_drain_ready2 got %0b want 0", samp_in_ready); end
        n_cmp++; if (subSample_RnnnnU !== 4'b1000) begin n_err++; $display("FAIL cfg_sub_hold got %b want 1000", subSample_RnnnnU); end
        tick();
        n_cmp++; if (subSample_RnnnnU !== 4'b0010) begin n_err++; $display("FAIL cfg_sub_load got %b want 0010", subSample_RnnnnU); end
        n_cmp++; if (samp_in_ready !== 1'b1) begin n_err++; $display("FAIL cfg_back_ready got %0b want 1", samp_in_ready); end
        tick();
        n_cmp++; if (subSample_RnnnnU !== 4'b0010) begin n_err++; $display("FAIL cfg_ignored got %b want 0010", subSample_RnnnnU); end
        n_cmp++; if (err_H !== 1'b0) begin n_err++; $display("FAIL cfg_err got %0b want 0", err_H); end
        $display("test_cfg done");
    endtask

    task automatic test_cfg_partial();
        samp_in_valid = 1'b1; samp_in_last = 1'b0; samp_in_S = pc;
        tick();
        samp_in_valid = 1'b0;
        cfg_load = 1'b1; cfg_sub_in = 4'b0100;
        tick();
        cfg_load = 1'b0;
        n_cmp++; if (samp_in_ready !== 1'b1) begin n_err++; $display("FAIL part_ready got %0b want 1", samp_in_ready); end
        samp_in_valid = 1'b1; samp_in_S = pd;
        tick();
        samp_in_valid = 1'b0;
        n_cmp++; if (issue_R14H !== 1'b1) begin n_err++; $display("FAIL part_issue got %0b want 1", issue_R14H); end
        n_cmp++; if (validSamp_R14H !== 2'b11) begin n_err++; $display("FAIL part_vld got %b want 11", validSamp_R14H); end
        n_cmp++; if (sample_R14S[0] !== pc) begin n_err++; $display("FAIL part_lane0 got %h want %h", sample_R14S[0], pc); end
        n_cmp++; if (samp_in_ready !== 1'b0) begin n_err++; $display("FAIL part_drain_ready got %0b want 0", samp_in_ready); end
        pulse_credit();
        n_cmp++; if (subSample_RnnnnU !== 4'b0010) begin n_err++; $display("FAIL part_sub_early got %b want 0010", subSample_RnnnnU); end
        tick();
        n_cmp++; if (subSample_RnnnnU !== 4'b0100) begin n_err++; $display("FAIL part_sub got %b want 0100", subSample_RnnnnU); end
        n_cmp++; if (samp_in_ready !== 1'b1) begin n_err++; $display("FAIL part_back_ready got %0b want 1", samp_in_ready); end
        $display("test_cfg_partial done");
    endtask

    task automatic test_cfg_bad();
        cfg_load = 1'b1; cfg_sub_in = 4'b0110;
        tick();
        cfg_load = 1'b0;
        tick();
        n_cmp++; if (err_H !== 1'b1) begin n_err++; $display("FAIL bad_err got %0b want 1", err_H); end
        n_cmp++; if (subSample_RnnnnU !== 4'b0100) begin n_err++; $display("FAIL bad_sub got %b want 0100", subSample_RnnnnU); end
        n_cmp++; if (samp_in_ready !== 1'b1) begin n_err++; $display("FAIL bad_ready got %0b want 1", samp_in_ready); end
        $display("test_cfg_bad done");
    endtask

    initial begin
        test_reset();
        test_pair();
        test_last();
        test_hold();
        test_credit_overflow();
        test_reset_mid();
        test_cfg();
        test_cfg_partial();
        test_cfg_bad();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
